multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle main decoder. Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB phases instead of decoding in one combinational step.
- Drives the same datapath select signals plus phase enables (PC write, IR write) and a req/ready handshake to a shared instruction/data memory.
- Adds optional LUI/AUIPC support, an illegal-opcode trap mode and a retired-instruction counter.
- Sits between the IR opcode field, the ALU branch-compare flag and the memory port.

Parameters:
- SUPPORT_UPPER, 1: 1 decodes LUI (0110111) and AUIPC (0010111); 0 treats them as illegal.
- TRAP_ON_ILLEGAL, 1: 1 sends unknown opcodes to TRAP; 0 retires them as NOPs.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- opcode  in  7  IR[6:0]; valid from DECODE onward
- branch_taken  in  1  ALU compare result for the current branch; sampled in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (store); qualifies mem_req
- ir_wr  out  1  load IR from memory read data
- pc_wr  out  1  update PC this cycle
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- alu_src  out  1  0 rs2, 1 immediate
- alu_a_src  out  2  00 rs1, 01 PC, 10 zero
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- reg_wr  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 0 ALU, 1 load data
- uncond_jump  out  1  writeback value is PC+4
- illegal  out  1  high while in TRAP
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The state is registered. Outputs are combinational from the state and the opcode latched in DECODE (opc_q).
- Reset: the state goes to FETCH, opc_q and instret go to 0, and all outputs are 0 during the rst cycle. mem_req rises in the first cycle after rst falls. A rst that arrives mid-instruction (including MEM with mem_req high) aborts it: no pc_wr, reg_wr or instret increment, and mem_req is low in the following cycle.
- FETCH: mem_req=1, mem_we=0. The block stays in FETCH while mem_ready=0. When mem_ready=1 it asserts ir_wr=1 and moves to DECODE.
- DECODE: latches opc_q=opcode and moves to EXEC. An unknown opcode, or an upper-immediate opcode with SUPPORT_UPPER=0, goes to TRAP if TRAP_ON_ILLEGAL=1. Otherwise it goes to WB with reg_wr=0 and pc_src=00 (NOP).
- EXEC: alu_src, alu_a_src and alu_op are driven per opcode: R 0/00/10, I 1/00/11, load/store 1/00/00, branch 0/00/01, JAL/JALR 1/00/00, LUI 1/10/00, AUIPC 1/01/00.
  - Branch: pc_wr=1; pc_src=01 if branch_taken, else 00; then back to FETCH. A branch retires here.
  - Load/store: go to MEM.
  - All other opcodes: go to WB.
- MEM: mem_req=1; mem_we=1 for a store. The block holds while mem_ready=0. On mem_ready=1:
  - a store retires (pc_wr=1, pc_src=00) and returns to FETCH;
  - a load goes to WB.
- WB: reg_wr=1 except for a NOP; mem_to_reg=1 for a load; uncond_jump=1 for JAL/JALR; pc_wr=1. pc_src is 01 for JAL, 10 for JALR, 00 otherwise. Then back to FETCH.
- Retire: instret increments by 1 on every pc_wr cycle and wraps modulo 2^CNT_W.
- TRAP: illegal=1; all enables (mem_req, mem_we, ir_wr, pc_wr, reg_wr) are 0; the block stays in TRAP until rst.
- Mutual exclusion: pc_wr and ir_wr are never high in the same cycle, and mem_we is never high without mem_req.
- Latency with mem_ready tied high: branch 3 cycles; R/I/JAL/JALR/LUI/AUIPC/store 4; load 5. Each cycle of mem_ready=0 adds one cycle in FETCH or MEM.

Decomposition:
- Package ctrl_pkg holds:
  - the opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - typedef enum logic [2:0] state_t;
  - encodings for alu_op, pc_src and alu_a_src.
- One natural sub-module, opcode_decode: purely combinational; maps opc_q to the per-opcode select fields and the legal flag.

Test Plan:
- rst=1 for 2 cycles, then R-type 0110011 with mem_ready=1 -> states FETCH,DECODE,EXEC,WB; reg_wr=1, alu_op=10 in WB only; instret=1 after 4 cycles.
- Load 0000011 with mem_ready low for 3 cycles in MEM -> mem_req held for 4 cycles; in WB reg_wr=1 and mem_to_reg=1; total latency 8 cycles.
- Branch 1100011 with branch_taken=1, then branch_taken=0 -> pc_src=01, then 00, each with a single pc_wr pulse in EXEC; reg_wr never asserted.
- JALR 1100111 -> WB with pc_src=10, uncond_jump=1, reg_wr=1; AUIPC 0010111 with SUPPORT_UPPER=1 -> alu_a_src=01 in EXEC.
- Opcode 1111111 with TRAP_ON_ILLEGAL=1 -> illegal=1 from the cycle after DECODE, all enables 0 for 20 cycles; rst returns to FETCH. With TRAP_ON_ILLEGAL=0 -> NOP retire, instret+1, reg_wr=0.
- Store with rst asserted in MEM while mem_ready=0 -> next cycle mem_req=0, state FETCH, instret=0, no mem_we after rst; CNT_W=4 run 17 instructions -> instret=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the opcode constants, the FSM state type, the encodings of the
// datapath select fields (alu_op, pc_src, alu_a_src) and a legality helper
// used both by the FSM (on the live IR opcode in DECODE) and by the decoder
// (on the latched opcode).
package ctrl_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  // pc_src encodings
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_REG   = 2'b10;

  // alu_a_src encodings
  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  // True when the opcode is one this control unit sequences. Upper-immediate
  // opcodes are legal only when the build supports them.
  function automatic logic opc_legal(input logic [6:0] opc, input logic support_upper);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR:  opc_legal = 1'b1;
      OPC_LUI, OPC_AUIPC:             opc_legal = support_upper;
      default:                        opc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Purely combinational opcode decoder.
// Maps the latched opcode to the per-opcode ALU select fields, the
// instruction-class flags used by the sequencer and the legal flag.
// Ports:
//   opc        in  7  latched opcode
//   legal      out 1  opcode is sequenced (otherwise a NOP or trap)
//   is_load / is_store / is_branch / is_jal / is_jalr  out 1  class flags
//   alu_src    out 1  0 rs2, 1 immediate
//   alu_a_src  out 2  00 rs1, 01 PC, 10 zero
//   alu_op     out 2  00 add, 01 branch compare, 10 R funct, 11 I funct
module opcode_decode
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input  logic [6:0] opc,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       alu_src,
  output logic [1:0] alu_a_src,
  output logic [1:0] alu_op
);

  always_comb begin
    legal     = opc_legal(opc, SUPPORT_UPPER);
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    alu_src   = 1'b0;
    alu_a_src = A_RS1;
    alu_op    = ALU_ADD;
    case (opc)
      OPC_R:      alu_op = ALU_RTYPE;
      OPC_I: begin
        alu_src = 1'b1;
        alu_op  = ALU_ITYPE;
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        alu_src = 1'b1;
      end
      OPC_STORE: begin
        is_store = 1'b1;
        alu_src  = 1'b1;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_BR;
      end
      OPC_JAL: begin
        is_jal  = 1'b1;
        alu_src = 1'b1;
      end
      OPC_JALR: begin
        is_jalr = 1'b1;
        alu_src = 1'b1;
      end
      OPC_LUI: begin
        if (SUPPORT_UPPER) begin
          alu_src   = 1'b1;
          alu_a_src = A_ZERO;
        end
      end
      OPC_AUIPC: begin
        if (SUPPORT_UPPER) begin
          alu_src   = 1'b1;
          alu_a_src = A_PC;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB plus TRAP.
// Outputs are combinational from the registered state and the opcode
// latched in DECODE (opc_q); every output is forced low while rst is high.
//
// Memory handshake: mem_req is held high for the whole FETCH or MEM phase;
// the access completes in the cycle where mem_req and mem_ready are both
// high, and the FSM advances on that edge. mem_we only qualifies mem_req.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   opcode          IR[6:0], valid from DECODE onward
//   branch_taken    ALU compare result, used in EXEC for branches
//   mem_ready       memory completes the current request this cycle
//   mem_req/mem_we  memory request / store qualifier
//   ir_wr, pc_wr    IR load and PC update enables
//   pc_src          00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   alu_src, alu_a_src, alu_op   ALU operand/operation selects
//   reg_wr, mem_to_reg, uncond_jump   writeback controls
//   illegal         high while trapped
//   instret         retired-instruction count (wraps)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_UPPER   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_a_src,
  output logic [1:0]       alu_op,
  output logic             reg_wr,
  output logic             mem_to_reg,
  output logic             uncond_jump,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [6:0] opc_q;

  logic       d_legal;
  logic       d_load;
  logic       d_store;
  logic       d_branch;
  logic       d_jal;
  logic       d_jalr;
  logic       d_alu_src;
  logic [1:0] d_alu_a_src;
  logic [1:0] d_alu_op;

  opcode_decode #(
    .SUPPORT_UPPER(SUPPORT_UPPER)
  ) u_decode (
    .opc       (opc_q),
    .legal     (d_legal),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_branch (d_branch),
    .is_jal    (d_jal),
    .is_jalr   (d_jalr),
    .alu_src   (d_alu_src),
    .alu_a_src (d_alu_a_src),
    .alu_op    (d_alu_op)
  );

  // Sequencer state, latched opcode and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      opc_q   <= '0;
      instret <= '0;
    end else begin
      // Every instruction ends with exactly one pc_wr cycle, so that is the
      // retire event.
      if (pc_wr) instret <= instret + CNT_ONE;
      case (state)
        FETCH: if (mem_ready) state <= DECODE;
        DECODE: begin
          opc_q <= opcode;
          // Legality is judged on the live IR here; opc_q is not yet valid.
          if (opc_legal(opcode, SUPPORT_UPPER)) state <= EXEC;
          else if (TRAP_ON_ILLEGAL)             state <= TRAP;
          else                                  state <= WB;
        end
        EXEC: begin
          if (d_branch)               state <= FETCH;
          else if (d_load || d_store) state <= MEM;
          else                        state <= WB;
        end
        MEM: if (mem_ready) state <= d_store ? FETCH : WB;
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath controls. ALU selects stay valid through MEM and WB so the
  // address / result path does not depend on when the datapath samples it.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = PC_PLUS4;
    alu_src     = 1'b0;
    alu_a_src   = A_RS1;
    alu_op      = ALU_ADD;
    reg_wr      = 1'b0;
    mem_to_reg  = 1'b0;
    uncond_jump = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
        end
        DECODE: ;
        EXEC: begin
          alu_src   = d_alu_src;
          alu_a_src = d_alu_a_src;
          alu_op    = d_alu_op;
          if (d_branch) begin
            pc_wr  = 1'b1;
            pc_src = branch_taken ? PC_IMM : PC_PLUS4;
          end
        end
        MEM: begin
          mem_req   = 1'b1;
          mem_we    = d_store;
          alu_src   = d_alu_src;
          alu_a_src = d_alu_a_src;
          alu_op    = d_alu_op;
          if (mem_ready && d_store) pc_wr = 1'b1;
        end
        WB: begin
          pc_wr     = 1'b1;
          alu_src   = d_alu_src;
          alu_a_src = d_alu_a_src;
          alu_op    = d_alu_op;
          // An illegal opcode only reaches WB as a NOP: retire, write nothing.
          if (d_legal) begin
            reg_wr      = 1'b1;
            mem_to_reg  = d_load;
            uncond_jump = d_jal || d_jalr;
            if (d_jal)       pc_src = PC_IMM;
            else if (d_jalr) pc_src = PC_REG;
          end
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Output vector bit order:
// {mem_req, mem_we, ir_wr, pc_wr, pc_src[1:0], alu_src, alu_a_src[1:0],
//  alu_op[1:0], reg_wr, mem_to_reg, uncond_jump, illegal}
module tb_multicycle_control;
  import ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic [6:0] opcode, opcode2;
  logic       branch_taken, branch_taken2;
  logic       mem_ready, mem_ready2;

  logic        mem_req, mem_we, ir_wr, pc_wr, alu_src, reg_wr, mem_to_reg, uncond_jump, illegal;
  logic [1:0]  pc_src, alu_a_src, alu_op;
  logic [31:0] instret;

  logic        mem_req2, mem_we2, ir_wr2, pc_wr2, alu_src2, reg_wr2, mem_to_reg2, uncond_jump2, illegal2;
  logic [1:0]  pc_src2, alu_a_src2, alu_op2;
  logic [3:0]  instret2;

  logic [14:0] outs, outs2;
  assign outs  = {mem_req, mem_we, ir_wr, pc_wr, pc_src, alu_src, alu_a_src, alu_op,
                  reg_wr, mem_to_reg, uncond_jump, illegal};
  assign outs2 = {mem_req2, mem_we2, ir_wr2, pc_wr2, pc_src2, alu_src2, alu_a_src2, alu_op2,
                  reg_wr2, mem_to_reg2, uncond_jump2, illegal2};

  multicycle_control #(
    .SUPPORT_UPPER(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .pc_src(pc_src), .alu_src(alu_src), .alu_a_src(alu_a_src),
    .alu_op(alu_op), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg),
    .uncond_jump(uncond_jump), .illegal(illegal), .instret(instret)
  );

  multicycle_control #(
    .SUPPORT_UPPER(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .branch_taken(branch_taken2),
    .mem_ready(mem_ready2), .mem_req(mem_req2), .mem_we(mem_we2), .ir_wr(ir_wr2),
    .pc_wr(pc_wr2), .pc_src(pc_src2), .alu_src(alu_src2), .alu_a_src(alu_a_src2),
    .alu_op(alu_op2), .reg_wr(reg_wr2), .mem_to_reg(mem_to_reg2),
    .uncond_jump(uncond_jump2), .illegal(illegal2), .instret(instret2)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 32'd0;

  localparam logic [14:0] O_FETCH_RDY  = 15'b1010_00_0_00_00_0000;
  localparam logic [14:0] O_FETCH_WAIT = 15'b1000_00_0_00_00_0000;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (dut.state !== FETCH) begin bad++; $display("FAIL reset_state[%0d]: got %0d want %0d", i, dut.state, FETCH); end
      total++; if (outs !== 15'b0) begin bad++; $display("FAIL reset_outs[%0d]: got %b want %b", i, outs, 15'b0); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret[%0d]: got %0d want 0", i, instret); end
    end
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_FETCH_WAIT) begin bad++; $display("FAIL reset_release_outs: got %b want %b", outs, O_FETCH_WAIT); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    state_t      es [4] = '{FETCH, DECODE, EXEC, WB};
    logic [14:0] eo [4] = '{O_FETCH_RDY, 15'b0, 15'b0000_00_0_00_10_0000, 15'b0001_00_0_00_10_1000};
    opcode = OPC_R; mem_ready = 1'b1; branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (dut.state !== es[i]) begin bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, dut.state, es[i]); end
      total++; if (outs !== eo[i]) begin bad++; $display("FAIL rtype_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      @(posedge clk); #1;
    end
    exp_instret = exp_instret + 32'd1;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL rtype_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_load_wait();
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    state_t      es  [8] = '{FETCH, DECODE, EXEC, MEM, MEM, MEM, MEM, WB};
    logic [14:0] eo  [8] = '{O_FETCH_RDY, 15'b0, 15'b0000_00_1_00_00_0000,
                             15'b1000_00_1_00_00_0000, 15'b1000_00_1_00_00_0000,
                             15'b1000_00_1_00_00_0000, 15'b1000_00_1_00_00_0000,
                             15'b0001_00_1_00_00_1100};
    opcode = OPC_LOAD; branch_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      total++; if (dut.state !== es[i]) begin bad++; $display("FAIL load_state[%0d]: got %0d want %0d", i, dut.state, es[i]); end
      total++; if (outs !== eo[i]) begin bad++; $display("FAIL load_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      @(posedge clk); #1;
    end
    exp_instret = exp_instret + 32'd1;
    total++; if (dut.state !== FETCH) begin bad++; $display("FAIL load_done_state: got %0d want %0d", dut.state, FETCH); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL load_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_branch();
    logic [14:0] eo [2][3] = '{'{O_FETCH_RDY, 15'b0, 15'b0001_01_0_00_01_0000},
                               '{O_FETCH_RDY, 15'b0, 15'b0001_00_0_00_01_0000}};
    state_t      es [3] = '{FETCH, DECODE, EXEC};
    opcode = OPC_BRANCH; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      branch_taken = (k == 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        total++; if (dut.state !== es[i]) begin bad++; $display("FAIL branch%0d_state[%0d]: got %0d want %0d", k, i, dut.state, es[i]); end
        total++; if (outs !== eo[k][i]) begin bad++; $display("FAIL branch%0d_outs[%0d]: got %b want %b", k, i, outs, eo[k][i]); end
        @(posedge clk); #1;
      end
      exp_instret = exp_instret + 32'd1;
      total++; if (instret !== exp_instret) begin bad++; $display("FAIL branch%0d_instret: got %0d want %0d", k, instret, exp_instret); end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jalr_auipc();
    logic [6:0]  opc [2] = '{OPC_JALR, OPC_AUIPC};
    logic [14:0] eo [2][4] = '{
      '{O_FETCH_RDY, 15'b0, 15'b0000_00_1_00_00_0000, 15'b0001_10_1_00_00_1010},
      '{O_FETCH_RDY, 15'b0, 15'b0000_00_1_01_00_0000, 15'b0001_00_1_01_00_1000}};
    state_t      es [4] = '{FETCH, DECODE, EXEC, WB};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = opc[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++; if (dut.state !== es[i]) begin bad++; $display("FAIL jump_upper%0d_state[%0d]: got %0d want %0d", k, i, dut.state, es[i]); end
        total++; if (outs !== eo[k][i]) begin bad++; $display("FAIL jump_upper%0d_outs[%0d]: got %b want %b", k, i, outs, eo[k][i]); end
        @(posedge clk); #1;
      end
      exp_instret = exp_instret + 32'd1;
      total++; if (instret !== exp_instret) begin bad++; $display("FAIL jump_upper%0d_instret: got %0d want %0d", k, instret, exp_instret); end
    end
  endtask

  task automatic test_store();
    state_t      es [4] = '{FETCH, DECODE, EXEC, MEM};
    logic [14:0] eo [4] = '{O_FETCH_RDY, 15'b0, 15'b0000_00_1_00_00_0000, 15'b1101_00_1_00_00_0000};
    opcode = OPC_STORE; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (dut.state !== es[i]) begin bad++; $display("FAIL store_state[%0d]: got %0d want %0d", i, dut.state, es[i]); end
      total++; if (outs !== eo[i]) begin bad++; $display("FAIL store_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      @(posedge clk); #1;
    end
    exp_instret = exp_instret + 32'd1;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL store_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_trap();
    state_t      es;
    logic [14:0] eo;
    opcode = 7'b1111111; mem_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      es = (i == 0) ? FETCH : (i == 1) ? DECODE : TRAP;
      eo = (i == 0) ? O_FETCH_RDY : (i == 1) ? 15'b0 : 15'b0000_00_0_00_00_0001;
      @(negedge clk);
      total++; if (dut.state !== es) begin bad++; $display("FAIL trap_state[%0d]: got %0d want %0d", i, dut.state, es); end
      total++; if (outs !== eo) begin bad++; $display("FAIL trap_outs[%0d]: got %b want %b", i, outs, eo); end
      @(posedge clk); #1;
    end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL trap_instret: got %0d want %0d", instret, exp_instret); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (outs !== 15'b0) begin bad++; $display("FAIL trap_rst_outs: got %b want %b", outs, 15'b0); end
    @(posedge clk); #1;
    exp_instret = 32'd0;
    total++; if (dut.state !== FETCH) begin bad++; $display("FAIL trap_rst_state: got %0d want %0d", dut.state, FETCH); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL trap_rst_instret: got %0d want 0", instret); end
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_FETCH_WAIT) begin bad++; $display("FAIL trap_release_outs: got %b want %b", outs, O_FETCH_WAIT); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_abort();
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    state_t      es  [5] = '{FETCH, DECODE, EXEC, MEM, MEM};
    logic [14:0] eo  [5] = '{O_FETCH_RDY, 15'b0, 15'b0000_00_1_00_00_0000,
                             15'b1100_00_1_00_00_0000, 15'b1100_00_1_00_00_0000};
    opcode = OPC_STORE;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      total++; if (dut.state !== es[i]) begin bad++; $display("FAIL abort_state[%0d]: got %0d want %0d", i, dut.state, es[i]); end
      total++; if (outs !== eo[i]) begin bad++; $display("FAIL abort_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (outs !== 15'b0) begin bad++; $display("FAIL abort_rst_outs: got %b want %b", outs, 15'b0); end
    @(posedge clk); #1;
    exp_instret = 32'd0;
    total++; if (dut.state !== FETCH) begin bad++; $display("FAIL abort_rst_state: got %0d want %0d", dut.state, FETCH); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL abort_rst_instret: got %0d want 0", instret); end
    @(negedge clk);
    total++; if (outs !== 15'b0) begin bad++; $display("FAIL abort_next_outs: got %b want %b", outs, 15'b0); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_FETCH_WAIT) begin bad++; $display("FAIL abort_release_outs: got %b want %b", outs, O_FETCH_WAIT); end
    @(posedge clk); #1;
  endtask

  // Second build: no upper-immediate support, illegal opcodes retire as
  // NOPs, 4-bit counter. 17 retirements wrap the counter to 1.
  task automatic test_cnt_wrap_nop();
    logic [6:0]  opc  [4] = '{OPC_R, OPC_LUI, 7'b1111111, OPC_BRANCH};
    int          elat [4] = '{4, 3, 3, 3};
    logic [14:0] eo   [4] = '{15'b0001_00_0_00_10_1000, 15'b0001_00_0_00_00_0000,
                              15'b0001_00_0_00_00_0000, 15'b0001_00_0_00_01_0000};
    int cyc;
    bit seen;
    rst2 = 1'b0; mem_ready2 = 1'b1; branch_taken2 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      opcode2 = opc[k % 4];
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 12) begin
        @(negedge clk);
        cyc++;
        if (pc_wr2) begin
          seen = 1'b1;
          total++; if (outs2 !== eo[k % 4]) begin bad++; $display("FAIL cnt_retire_outs[%0d]: got %b want %b", k, outs2, eo[k % 4]); end
        end
        @(posedge clk); #1;
      end
      total++; if (!seen || cyc != elat[k % 4]) begin bad++; $display("FAIL cnt_latency[%0d]: got %0d want %0d", k, seen ? cyc : -1, elat[k % 4]); end
      if (k == 0) begin
        total++; if (instret2 !== 4'd1) begin bad++; $display("FAIL cnt_first: got %0d want 1", instret2); end
      end
      if (k == 15) begin
        total++; if (instret2 !== 4'd0) begin bad++; $display("FAIL cnt_wrap16: got %0d want 0", instret2); end
      end
    end
    total++; if (instret2 !== 4'd1) begin bad++; $display("FAIL cnt_wrap17: got %0d want 1", instret2); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; rst2 = 1'b1;
    opcode = 7'd0; opcode2 = 7'd0;
    branch_taken = 1'b0; branch_taken2 = 1'b0;
    mem_ready = 1'b0; mem_ready2 = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jalr_auipc();
    test_store();
    test_trap();
    test_rtype();
    test_rst_abort();
    test_cnt_wrap_nop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
